mem_arbiter: RTL and testbench

Parametrised byte-serial memory controller between `NUM_CH` requesters (instruction fetch, load/store, future prefetch or DMA ports) and the CPU's single 8-bit memory bus. It round-robin-arbitrates requests and serialises 1/2/4-byte reads and writes into per-byte bus cycles. It also assembles read data with optional sign extension, aborts speculative reads on pipeline flush, and can stall UART writes when the I/O buffer is full.

---
 rtl/mem_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin byte-serial memory arbiter; optional UART write stall via MEMARB_IO_STALL_EN
module mem_arbiter #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush_in,
    input  logic [NUM_CH-1:0]        req_valid,
    input  logic [NUM_CH-1:0]        req_wr,
    input  logic [2*NUM_CH-1:0]      req_size,
    input  logic [NUM_CH-1:0]        req_signed,
    input  logic [ADDR_W*NUM_CH-1:0] req_addr,
    input  logic [32*NUM_CH-1:0]     req_wdata,
    output logic [NUM_CH-1:0]        resp_ready,
    output logic [31:0]              resp_data,
    input  logic [7:0]               mem_din,
    output logic [7:0]               mem_dout,
    output logic [31:0]              mem_a,
    output logic                     mem_wr,
    input  logic                     io_buffer_full
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_READ   = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_IOWAIT = 2'd3;

    logic [1:0]        state;
    logic [CH_W-1:0]   last_grant;
    logic [CH_W-1:0]   lat_ch;
    logic [ADDR_W-1:0] lat_addr;
    logic [2:0]        lat_n;
    logic              lat_signed;
    logic [31:0]       lat_wdata;
    logic [2:0]        cnt;
    logic              mem_wr_q;

    logic              grant_valid;
    logic [CH_W-1:0]   grant_ch;
    logic [ADDR_W-1:0] addr_arr [NUM_CH];
    logic [1:0]        size_arr [NUM_CH];
    logic [31:0]       wdata_arr [NUM_CH];
    logic [ADDR_W-1:0] g_addr;
    logic [ADDR_W-1:0] nxt_addr;
    logic [2:0]        cnt_nxt;
    logic [1:0]        cap_idx;
    logic [31:0]       read_word;
    logic              g_io_stall;
    logic              nxt_io_stall;
    logic              io_hold;

    function automatic logic [2:0] size_bytes(input logic [1:0] s);
        case (s)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Channel index off steps past base, wrapping at NUM_CH
    function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int off);
        return CH_W'((int'(base) + off) % NUM_CH);
    endfunction

    // Split the flat request buses into per-channel fields
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
            size_arr[i]  = req_size[i*2 +: 2];
            wdata_arr[i] = req_wdata[i*32 +: 32];
        end
    end

    // Round-robin search from last_grant+1; a channel completing this cycle is skipped
    always_comb begin
        grant_valid = 1'b0;
        grant_ch    = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!grant_valid && req_valid[rr_idx(last_grant, i)] && !resp_ready[rr_idx(last_grant, i)]) begin
                grant_valid = 1'b1;
                grant_ch    = rr_idx(last_grant, i);
            end
        end
    end

    assign g_addr   = addr_arr[grant_ch];
    assign cnt_nxt  = cnt + 3'd1;
    assign nxt_addr = lat_addr + ADDR_W'(cnt_nxt);
    assign cap_idx  = 2'(cnt - 3'd1);

`ifdef MEMARB_IO_STALL_EN
    logic [31:0] g_a32;
    logic [31:0] nxt_a32;
    assign g_a32        = 32'(g_addr);
    assign nxt_a32      = 32'(nxt_addr);
    assign io_hold      = io_buffer_full;
    assign g_io_stall   = (g_a32[17:16] == 2'b11) && io_hold;
    assign nxt_io_stall = (nxt_a32[17:16] == 2'b11) && io_hold;
`else
    logic unused_io;
    assign unused_io    = io_buffer_full;
    assign io_hold      = 1'b0;
    assign g_io_stall   = 1'b0;
    assign nxt_io_stall = 1'b0;
`endif

    // Final read word: insert the byte arriving now, then sign- or zero-extend
    always_comb begin
        read_word = resp_data;
        read_word[{cap_idx, 3'b000} +: 8] = mem_din;
        if (lat_signed && lat_n == 3'd1) begin
            read_word[31:8] = {24{read_word[7]}};
        end else if (lat_signed && lat_n == 3'd2) begin
            read_word[31:16] = {16{read_word[15]}};
        end
    end

    // Write strobe is the only output not purely registered: freezing drops it at once
    assign mem_wr = mem_wr_q & rdy_in;

    // Arbitration and byte sequencing; everything holds while rdy_in is low
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= S_IDLE;
            last_grant <= CH_W'(NUM_CH - 1);
            lat_ch     <= '0;
            lat_addr   <= '0;
            lat_n      <= 3'd1;
            lat_signed <= 1'b0;
            lat_wdata  <= '0;
            cnt        <= '0;
            mem_a      <= '0;
            mem_dout   <= '0;
            mem_wr_q   <= 1'b0;
            resp_ready <= '0;
            resp_data  <= '0;
        end else if (rdy_in) begin
            resp_ready <= '0;
            case (state)
                S_IDLE: begin
                    mem_a    <= '0;
                    mem_dout <= '0;
                    mem_wr_q <= 1'b0;
                    if (grant_valid && !flush_in) begin
                        last_grant <= grant_ch;
                        lat_ch     <= grant_ch;
                        lat_addr   <= g_addr;
                        lat_n      <= size_bytes(size_arr[grant_ch]);
                        lat_signed <= req_signed[grant_ch];
                        lat_wdata  <= wdata_arr[grant_ch];
                        cnt        <= 3'd0;
                        mem_a      <= 32'(g_addr);
                        resp_data  <= '0;
                        if (req_wr[grant_ch]) begin
                            mem_dout <= wdata_arr[grant_ch][7:0];
                            if (g_io_stall) begin
                                state <= S_IOWAIT;
                            end else begin
                                state    <= S_WRITE;
                                mem_wr_q <= 1'b1;
                            end
                        end else begin
                            state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (flush_in) begin
                        state <= S_IDLE;
                        mem_a <= '0;
                    end else if (cnt == lat_n) begin
                        resp_data          <= read_word;
                        resp_ready[lat_ch] <= 1'b1;
                        state              <= S_IDLE;
                        mem_a              <= '0;
                    end else begin
                        if (cnt != 3'd0) begin
                            resp_data[{cap_idx, 3'b000} +: 8] <= mem_din;
                        end
                        cnt   <= cnt_nxt;
                        mem_a <= (cnt_nxt < lat_n) ? 32'(nxt_addr) : 32'd0;
                    end
                end
                S_WRITE: begin
                    if (cnt_nxt == lat_n) begin
                        resp_ready[lat_ch] <= 1'b1;
                        resp_data          <= '0;
                        state              <= S_IDLE;
                        mem_a              <= '0;
                        mem_dout           <= '0;
                        mem_wr_q           <= 1'b0;
                    end else begin
                        cnt      <= cnt_nxt;
                        mem_a    <= 32'(nxt_addr);
                        mem_dout <= lat_wdata[{cnt_nxt[1:0], 3'b000} +: 8];
                        if (nxt_io_stall) begin
                            state    <= S_IOWAIT;
                            mem_wr_q <= 1'b0;
                        end
                    end
                end
                S_IOWAIT: begin
                    if (!io_hold) begin
                        state    <= S_WRITE;
                        mem_wr_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in, io_buffer_full;
    logic [1:0]  req_valid, req_wr, req_signed;
    logic [3:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  resp_ready;
    logic [31:0] resp_data;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0]  mem_m [logic [31:0]];
    logic [31:0] wr_log_a [$];
    logic [7:0]  wr_log_d [$];
    logic [31:0] a_seen = '0;
    logic [31:0] obs_a  [0:63];
    logic        obs_wr [0:63];
    logic [1:0]  obs_rr [0:63];

    mem_arbiter #(.NUM_CH(2), .ADDR_W(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_ready(resp_ready), .resp_data(resp_data),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    initial forever #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a, input logic [1:0] s, input logic sg);
        logic [31:0] v;
        int n;
        n = nbytes(s);
        v = 0;
        for (int k = 0; k < n; k++) v = v + (32'(mem_rd(a + 32'(k))) << (8 * k));
        if (sg && n == 1 && v >= 32'h80) v = v + 32'hFFFFFF00;
        if (sg && n == 2 && v >= 32'h8000) v = v + 32'hFFFF0000;
        return v;
    endfunction

    // Memory: a byte returns the cycle after its address; writes land in the model
    always @(negedge clk_in) begin
        a_seen = mem_a;
        if (mem_wr === 1'b1) begin
            wr_log_a.push_back(mem_a);
            wr_log_d.push_back(mem_dout);
            mem_m[mem_a] = mem_dout;
        end
    end

    always @(posedge clk_in) begin
        #1;
        mem_din = mem_rd(a_seen);
    end

    task automatic run_txn(input int ch, input logic wr, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata, input int flush_k,
                           input int frz_k, input int frz_len, input int io_len,
                           output int lat, output logic [31:0] rdata);
        wr_log_a.delete();
        wr_log_d.delete();
        req_wr[ch] = wr;
        req_size[2*ch +: 2] = size;
        req_signed[ch] = sgn;
        req_addr[32*ch +: 32] = addr;
        req_wdata[32*ch +: 32] = wdata;
        req_valid[ch] = 1'b1;
        lat = -1;
        rdata = '0;
        for (int k = 0; k < 48; k++) begin
            flush_in = (k == flush_k);
            rdy_in = !(k >= frz_k && k < frz_k + frz_len);
            io_buffer_full = (k < io_len);
            if (flush_k >= 0 && k > flush_k && !wr) req_valid[ch] = 1'b0;
            @(negedge clk_in);
            obs_a[k] = mem_a;
            obs_wr[k] = mem_wr;
            obs_rr[k] = resp_ready;
            if (resp_ready[ch]) begin
                lat = k;
                rdata = resp_data;
                req_valid[ch] = 1'b0;
            end
            @(posedge clk_in);
            #1;
            if (lat >= 0) break;
        end
        flush_in = 1'b0;
        rdy_in = 1'b1;
        io_buffer_full = 1'b0;
        req_valid[ch] = 1'b0;
    endtask

    task automatic test_reset;
        rst_in = 1'b1;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        tests_run++;
        if ({mem_a, mem_dout, mem_wr, resp_ready, resp_data} !== 75'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got a=%h dout=%h wr=%b rr=%b rd=%h required all zero",
                     mem_a, mem_dout, mem_wr, resp_ready, resp_data);
        end
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    task automatic test_single_read;
        int lat;
        logic [31:0] rd;
        mem_m[32'h100] = 8'h11; mem_m[32'h101] = 8'h22; mem_m[32'h102] = 8'h33; mem_m[32'h103] = 8'h44;
        run_txn(1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, -1, -1, 0, 0, lat, rd);
        for (int k = 1; k <= 4; k++) begin
            tests_run++;
            if (obs_a[k] !== 32'h100 + 32'(k - 1)) begin
                tests_failed++;
                $display("FAIL single_read_addr G+%0d: got %h required %h", k, obs_a[k], 32'h100 + 32'(k - 1));
            end
        end
        tests_run++;
        if (lat != 6 || rd !== 32'h44332211 || obs_rr[6] !== 2'b10) begin
            tests_failed++;
            $display("FAIL single_read_resp: got lat=%0d data=%h rr=%b required 6 44332211 10", lat, rd, obs_rr[6]);
        end
    endtask

    task automatic test_signed;
        logic [31:0] t_addr [3] = '{32'h300, 32'h300, 32'h1FF};
        logic [1:0]  t_size [3] = '{2'd0, 2'd0, 2'd1};
        logic        t_sgn  [3] = '{1'b1, 1'b0, 1'b1};
        logic [31:0] t_exp  [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFF234};
        int lat, n;
        logic [31:0] rd, a, ex;
        logic [1:0] s;
        logic sg;
        int ch;
        mem_m[32'h300] = 8'h80; mem_m[32'h1FF] = 8'h34; mem_m[32'h200] = 8'hF2;
        for (int i = 0; i < 3; i++) begin
            run_txn(0, 1'b0, t_size[i], t_sgn[i], t_addr[i], 32'h0, -1, -1, 0, 0, lat, rd);
            tests_run++;
            if (rd !== t_exp[i] || lat != nbytes(t_size[i]) + 2) begin
                tests_failed++;
                $display("FAIL signed_read_%0d: got data=%h lat=%0d required %h %0d", i, rd, lat, t_exp[i], nbytes(t_size[i]) + 2);
            end
        end
        for (int i = 0; i < 12; i++) begin
            a = (i % 4 == 3) ? 32'hFFFFFFFE : $urandom;
            s = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            ch = $urandom_range(0, 1);
            ex = exp_read(a, s, sg);
            n = nbytes(s);
            run_txn(ch, 1'b0, s, sg, a, 32'h0, -1, -1, 0, 0, lat, rd);
            tests_run++;
            if (rd !== ex || lat != n + 2) begin
                tests_failed++;
                $display("FAIL rand_read_%0d ch%0d a=%h s=%0d sg=%b: got data=%h lat=%0d required %h %0d",
                         i, ch, a, s, sg, rd, lat, ex, n + 2);
            end
        end
    endtask

    task automatic test_random_writes;
        int lat, n, ch;
        logic [31:0] rd, a, wd;
        logic [1:0] s;
        for (int i = 0; i < 8; i++) begin
            a = (i == 7) ? 32'hFFFFFFFF : $urandom;
            wd = $urandom;
            s = 2'($urandom_range(0, 3));
            ch = $urandom_range(0, 1);
            n = nbytes(s);
            run_txn(ch, 1'b1, s, 1'b0, a, wd, -1, -1, 0, 0, lat, rd);
            tests_run++;
            if (lat != n + 1 || rd !== 32'h0 || wr_log_a.size() != n) begin
                tests_failed++;
                $display("FAIL rand_write_%0d: got lat=%0d data=%h writes=%0d required %0d 0 %0d",
                         i, lat, rd, wr_log_a.size(), n + 1, n);
            end else begin
                for (int k = 0; k < n; k++) begin
                    tests_run++;
                    if (wr_log_a[k] !== a + 32'(k) || wr_log_d[k] !== 8'(wd >> (8 * k))) begin
                        tests_failed++;
                        $display("FAIL rand_write_%0d_byte%0d: got %h@%h required %h@%h",
                                 i, k, wr_log_d[k], wr_log_a[k], 8'(wd >> (8 * k)), a + 32'(k));
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0]  sz [2];
        logic [31:0] ex [2];
        int lt [2];
        int exp_ch, nresp, last_r, cyc, upd;
        logic [31:0] ad;
        logic sg;
        @(posedge clk_in); #1; rst_in = 1'b1;
        @(posedge clk_in); #1; rst_in = 1'b0;
        for (int c = 0; c < 2; c++) begin
            sz[c] = 2'($urandom_range(0, 3));
            ad = $urandom;
            sg = 1'($urandom_range(0, 1));
            req_wr[c] = 1'b0; req_size[2*c +: 2] = sz[c]; req_signed[c] = sg; req_addr[32*c +: 32] = ad;
            ex[c] = exp_read(ad, sz[c], sg);
            lt[c] = nbytes(sz[c]) + 2;
        end
        req_valid = 2'b11;
        exp_ch = 0; nresp = 0; last_r = 0; cyc = 0;
        while (nresp < 8 && cyc < 200) begin
            upd = -1;
            @(negedge clk_in);
            if (resp_ready !== 2'b00) begin
                tests_run++;
                if (resp_ready !== 2'(1 << exp_ch) || resp_data !== ex[exp_ch] || cyc != last_r + lt[exp_ch]) begin
                    tests_failed++;
                    $display("FAIL rr_order_%0d: got rr=%b data=%h cyc=%0d required rr=%b data=%h cyc=%0d",
                             nresp, resp_ready, resp_data, cyc, 2'(1 << exp_ch), ex[exp_ch], last_r + lt[exp_ch]);
                end
                last_r = cyc;
                nresp++;
                upd = exp_ch;
                exp_ch = exp_ch ^ 1;
                if (nresp == 8) req_valid = 2'b00;
            end
            @(posedge clk_in); #1;
            cyc++;
            if (upd >= 0) begin
                sz[upd] = 2'($urandom_range(0, 3));
                ad = $urandom;
                sg = 1'($urandom_range(0, 1));
                req_size[2*upd +: 2] = sz[upd]; req_signed[upd] = sg; req_addr[32*upd +: 32] = ad;
                ex[upd] = exp_read(ad, sz[upd], sg);
                lt[upd] = nbytes(sz[upd]) + 2;
            end
        end
        tests_run++;
        if (nresp != 8) begin
            tests_failed++;
            $display("FAIL rr_count: got %0d responses required 8", nresp);
        end
        req_valid = 2'b00;
        repeat (2) @(posedge clk_in);
        #1;
    endtask

    task automatic test_flush;
        int lat;
        logic [31:0] rd;
        int seen;
        run_txn(0, 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 2, -1, 0, 0, lat, rd);
        tests_run++;
        if (lat != -1 || obs_a[3] !== 32'h0) begin
            tests_failed++;
            $display("FAIL flush_read: got lat=%0d a@G+3=%h required no response and 0", lat, obs_a[3]);
        end
        run_txn(0, 1'b0, 2'd0, 1'b0, 32'h300, 32'h0, -1, -1, 0, 0, lat, rd);
        tests_run++;
        if (lat != 3 || rd !== 32'h80) begin
            tests_failed++;
            $display("FAIL flush_recover: got lat=%0d data=%h required 3 00000080", lat, rd);
        end
        run_txn(0, 1'b1, 2'd2, 1'b0, 32'h500, 32'hA1B2C3D4, 2, -1, 0, 0, lat, rd);
        seen = 0;
        for (int k = 1; k <= 4; k++) seen += int'(obs_wr[k]);
        tests_run++;
        if (lat != 5 || seen != 4 || wr_log_a.size() != 4) begin
            tests_failed++;
            $display("FAIL flush_write: got lat=%0d wr_cycles=%0d writes=%0d required 5 4 4", lat, seen, wr_log_a.size());
        end
    endtask

    task automatic test_freeze;
        int lat;
        logic [31:0] rd;
        run_txn(0, 1'b1, 2'd1, 1'b0, 32'h200, 32'h0000BEEF, -1, 2, 3, 0, lat, rd);
        tests_run++;
        if (obs_wr[2] !== 1'b0 || obs_wr[3] !== 1'b0 || obs_wr[4] !== 1'b0 || lat != 6) begin
            tests_failed++;
            $display("FAIL freeze_wr: got wr=%b%b%b lat=%0d required 000 6", obs_wr[2], obs_wr[3], obs_wr[4], lat);
        end
        tests_run++;
        if (wr_log_a.size() != 2) begin
            tests_failed++;
            $display("FAIL freeze_count: got %0d writes required 2", wr_log_a.size());
        end else if (wr_log_a[0] !== 32'h200 || wr_log_d[0] !== 8'hEF || wr_log_a[1] !== 32'h201 || wr_log_d[1] !== 8'hBE) begin
            tests_failed++;
            $display("FAIL freeze_bytes: got %h@%h %h@%h required EF@200 BE@201",
                     wr_log_d[0], wr_log_a[0], wr_log_d[1], wr_log_a[1]);
        end
    endtask

    task automatic test_io_stall;
        int lat;
        logic [31:0] rd;
        run_txn(1, 1'b1, 2'd0, 1'b0, 32'h30000, 32'h41, -1, -1, 0, 4, lat, rd);
`ifdef MEMARB_IO_STALL_EN
        tests_run++;
        if (obs_wr[1] !== 1'b0 || obs_wr[2] !== 1'b0 || obs_wr[3] !== 1'b0 || obs_wr[4] !== 1'b0 ||
            obs_wr[5] !== 1'b1 || lat != 6) begin
            tests_failed++;
            $display("FAIL io_stall: got wr=%b%b%b%b%b lat=%0d required 00001 6",
                     obs_wr[1], obs_wr[2], obs_wr[3], obs_wr[4], obs_wr[5], lat);
        end
`else
        tests_run++;
        if (obs_wr[1] !== 1'b1 || lat != 2) begin
            tests_failed++;
            $display("FAIL io_ignored: got wr=%b lat=%0d required 1 2", obs_wr[1], lat);
        end
`endif
        tests_run++;
        if (wr_log_a.size() != 1 || wr_log_a[0] !== 32'h30000 || wr_log_d[0] !== 8'h41) begin
            tests_failed++;
            $display("FAIL io_write: got %0d writes required one 41@00030000", wr_log_a.size());
        end
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; io_buffer_full = 1'b0;
        req_valid = '0; req_wr = '0; req_signed = '0; req_size = '0; req_addr = '0; req_wdata = '0;
        mem_din = '0;
        test_reset();
        test_single_read();
        test_signed();
        test_random_writes();
        test_back_to_back();
        test_flush();
        test_freeze();
        test_io_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
